register_bank_gpu_vec: RTL and testbench
========================================

Name: register_bank_gpu_vec

Overview:
Next-generation GPU vector register bank: REG_NUM registers, each LANES lanes of LANE_WIDTH bits, with one lane-masked write port and NUM_RD registered read ports. Register 0 reads as zero in every lane. A sequential clear engine zeroes the array after reset or on request, so the array itself carries no reset. It sits between the GPU shader decode stage (reads) and the writeback stage (writes).

Parameters:
REG_NUM, 32, number of vector registers; power of two, at least 2.
LANES, 4, lanes per register.
LANE_WIDTH, 32, bits per lane.
NUM_RD, 2, number of independent read ports.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  asynchronous active-low reset.
write_en  in  1  write request.
write_addr  in  $clog2(REG_NUM)  destination register.
write_mask  in  LANES  per-lane write enable; bit i covers lane i.
data_in  in  LANES*LANE_WIDTH  write data; lane i at bits [i*LANE_WIDTH +: LANE_WIDTH].
rd_en  in  NUM_RD  per-port read request.
rd_addr  in  NUM_RD*$clog2(REG_NUM)  per-port read address, packed.
rd_data  out  NUM_RD*LANES*LANE_WIDTH  per-port registered read data, packed.
rd_valid  out  NUM_RD  rd_data for that port is valid this cycle.
clear_req  in  1  request a full array clear (level; sampled when idle).
clear_busy  out  1  clear engine active; writes and reads are blocked.

Behaviour:
- Reset (reset=0): rd_data=0, rd_valid=0, clear_busy=1, FSM enters CLEAR with idx=1. Array contents are not reset.
- FSM states:
  - IDLE: clear_busy=0. clear_req=1 moves to CLEAR with idx=1 on the next edge.
  - CLEAR: writes zero to register idx, then idx++. At idx==REG_NUM-1, writes and moves to IDLE. Clearing takes REG_NUM-1 cycles.
- During CLEAR:
  - write_en is dropped silently.
  - rd_en is ignored and rd_valid=0.
  - clear_req has no effect.
- Write, IDLE only: on posedge with write_en=1 and write_addr!=0, lane i is updated iff write_mask[i]=1. write_mask=0 is a no-op. Writes to register 0 are discarded.
- Read latency is 1 cycle:
  - rd_en[p]=1 in cycle N gives rd_data[p] and rd_valid[p]=1 in cycle N+1.
  - rd_en[p]=0 gives rd_valid[p]=0 next cycle and rd_data[p] holds its previous value.
- Register 0 always returns all-zero lanes.
- Bypass: a same-cycle write and read to the same nonzero address returns the new data in masked lanes and the old data in unmasked lanes. Read-after-write is never stale.
- Multiple read ports may hit the same address in the same cycle; all receive identical data.
- Reset asserted mid-clear or mid-read: outputs are forced low immediately and the clear restarts from idx=1 after release.
- No arithmetic beyond idx increment; idx width is $clog2(REG_NUM) and never wraps past REG_NUM-1.

Optional Feature:
REG_BANK_PARITY_EN
- Defined:
  - Each lane stores one even-parity bit, computed on write and cleared to 0 by the clear engine.
  - Extra output parity_err [NUM_RD*LANES] is registered alongside rd_data and is 1 where a read lane's recomputed parity mismatches the stored bit. It is 0 when rd_valid is 0 and at reset.
  - Register 0 never flags.
- Undefined: no parity storage and no parity_err port.

Decomposition:
- Package reg_bank_gpu_pkg holds:
  - the FSM state enum typedef (IDLE, CLEAR);
  - the lane-vector typedef;
  - an even-parity function used when REG_BANK_PARITY_EN is defined.
- One sub-module, reg_bank_clear_fsm: owns the state, idx counter and clear_busy, and emits the zeroing write strobe and address to the top.
- Read ports are generated by a for-generate in the top module.

Test Plan:
- Release reset, hold rd_en=0 -> clear_busy=1 for exactly 31 cycles (REG_NUM=32), then 0. Reading r1..r31 then returns 0.
- Write r5 with data lanes {0xDDDD0003,0xCCCC0002,0xBBBB0001,0xAAAA0000}, mask=4'b1111; read r5 on port 0 next cycle -> rd_data equals the written data and rd_valid[0]=1 one cycle after rd_en.
- Write r5 with mask=4'b0101 and lanes 0x11111111, while port 1 reads r5 in the same cycle -> lanes 0 and 2 = 0x11111111, lanes 1 and 3 = prior values (bypass check).
- Write r0 with 0xFFFFFFFF in all lanes, mask=1111; read r0 on both ports -> all zero, rd_valid=2'b11.
- Pulse clear_req while writing r7=0x5 during busy -> write dropped, rd_valid=0 throughout the clear, r7 reads 0 afterwards.
- Assert reset for 1 cycle mid-clear (idx=10) -> rd_valid=0 immediately, clear restarts and busy lasts 31 cycles after release. With REG_BANK_PARITY_EN, force a stored data bit flip in r3 lane 2 -> parity_err for lane 2 = 1 on read.

Source files
------------

// File: rtl/reg_bank_gpu_pkg.sv
// Shared types and helpers for the GPU vector register bank.
// Optional build macro: REG_BANK_PARITY_EN (adds per-lane even parity storage).
package reg_bank_gpu_pkg;

  // Default geometry; the top-level parameters default to these values.
  localparam int unsigned DEF_REG_NUM    = 32;
  localparam int unsigned DEF_LANES      = 4;
  localparam int unsigned DEF_LANE_WIDTH = 32;
  localparam int unsigned DEF_NUM_RD     = 2;

  // Widest lane the parity helper accepts; narrower lanes are zero-extended.
  localparam int unsigned MAX_LANE_WIDTH = 64;

  // Clear-engine state.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // One full register (all lanes) at the default geometry.
  typedef logic [DEF_LANES*DEF_LANE_WIDTH-1:0] lane_vec_t;

  // Even-parity bit: stored bit plus data then has an even number of ones.
  function automatic logic even_parity(input logic [MAX_LANE_WIDTH-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/reg_bank_clear_fsm.sv
// Sequential clear engine: walks registers 1..REG_NUM-1 writing zero,
// one register per cycle, after reset or on a clear request.
module reg_bank_clear_fsm
  import reg_bank_gpu_pkg::*;
#(
  parameter int unsigned REG_NUM = DEF_REG_NUM,
  localparam int unsigned AW     = $clog2(REG_NUM)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear_req,
  output logic          o_clear_busy,
  output logic          o_clr_we,
  output logic [AW-1:0] o_clr_addr
);

  localparam logic [AW-1:0] FIRST_IDX = AW'(1);
  localparam logic [AW-1:0] LAST_IDX  = AW'(REG_NUM - 1);

  clr_state_e    r_state;
  clr_state_e    w_state_next;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idx_next;

  // State and index registers; reset starts a fresh clear from register 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CLEAR;
      r_idx   <= FIRST_IDX;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  // Next-state and zeroing-strobe logic; register 0 is never touched.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    o_clear_busy = 1'b0;
    o_clr_we     = 1'b0;
    o_clr_addr   = r_idx;
    case (r_state)
      IDLE: begin
        if (i_clear_req) begin
          w_state_next = CLEAR;
          w_idx_next   = FIRST_IDX;
        end
      end
      CLEAR: begin
        o_clear_busy = 1'b1;
        o_clr_we     = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_state_next = IDLE;
        end else begin
          w_idx_next = r_idx + 1'b1;
        end
      end
      default: begin
        w_state_next = CLEAR;
        w_idx_next   = FIRST_IDX;
      end
    endcase
  end

endmodule

// File: rtl/register_bank_gpu_vec.sv
// GPU vector register bank: REG_NUM registers of LANES x LANE_WIDTH bits,
// one lane-masked write port, NUM_RD registered read ports with write bypass.
// Register 0 reads as zero. The array has no reset; the clear engine zeroes it.
// Optional build macro: REG_BANK_PARITY_EN (per-lane parity and parity_err).
module register_bank_gpu_vec
  import reg_bank_gpu_pkg::*;
#(
  parameter int unsigned REG_NUM    = DEF_REG_NUM,
  parameter int unsigned LANES      = DEF_LANES,
  parameter int unsigned LANE_WIDTH = DEF_LANE_WIDTH,
  parameter int unsigned NUM_RD     = DEF_NUM_RD,
  localparam int unsigned AW        = $clog2(REG_NUM),
  localparam int unsigned WORD_W    = LANES * LANE_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write_en,
  input  logic [AW-1:0]              write_addr,
  input  logic [LANES-1:0]           write_mask,
  input  logic [WORD_W-1:0]          data_in,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*AW-1:0]       rd_addr,
`ifdef REG_BANK_PARITY_EN
  output logic [NUM_RD*LANES-1:0]    parity_err,
`endif
  output logic [NUM_RD*WORD_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_valid,
  input  logic                       clear_req,
  output logic                       clear_busy
);

  // Storage: no reset on the array itself.
  logic [WORD_W-1:0] r_mem [REG_NUM];

  logic          w_clear_busy;
  logic          w_clr_we;
  logic [AW-1:0] w_clr_addr;
  logic          w_wr_fire;

  reg_bank_clear_fsm #(
    .REG_NUM (REG_NUM)
  ) u_clear_fsm (
    .clk          (clk),
    .rst_n        (reset),
    .i_clear_req  (clear_req),
    .o_clear_busy (w_clear_busy),
    .o_clr_we     (w_clr_we),
    .o_clr_addr   (w_clr_addr)
  );

  assign clear_busy = w_clear_busy;

  // A user write only lands while idle and never on register 0.
  assign w_wr_fire = write_en && !w_clear_busy && (write_addr != '0);

  // Array write: clear engine zeroes whole registers, user writes are lane-masked.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_fire) begin
      for (int l = 0; l < LANES; l++) begin
        if (write_mask[l]) begin
          r_mem[write_addr][l*LANE_WIDTH +: LANE_WIDTH] <= data_in[l*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

`ifdef REG_BANK_PARITY_EN
  logic [LANES-1:0] r_par [REG_NUM];
  logic [LANES-1:0] w_wr_par;

  // Parity of each incoming lane, computed once and shared with the bypass.
  always_comb begin
    w_wr_par = '0;
    for (int l = 0; l < LANES; l++) begin
      w_wr_par[l] = even_parity(MAX_LANE_WIDTH'(data_in[l*LANE_WIDTH +: LANE_WIDTH]));
    end
  end

  // Parity array follows the data array write rules exactly.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_par[w_clr_addr] <= '0;
    end else if (w_wr_fire) begin
      for (int l = 0; l < LANES; l++) begin
        if (write_mask[l]) begin
          r_par[write_addr][l] <= w_wr_par[l];
        end
      end
    end
  end
`endif

  // One registered read port per generate iteration.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [AW-1:0]     w_addr;
    logic              w_hit;
    logic              w_fire;
    logic [WORD_W-1:0] w_word;
    logic [WORD_W-1:0] r_data;
    logic              r_valid;

    assign w_addr = rd_addr[gi*AW +: AW];
    assign w_hit  = w_wr_fire && (write_addr == w_addr);
    assign w_fire = rd_en[gi] && !w_clear_busy;

    // Read word with same-cycle write merged into masked lanes; r0 forced to zero.
    always_comb begin
      w_word = r_mem[w_addr];
      if (w_hit) begin
        for (int l = 0; l < LANES; l++) begin
          if (write_mask[l]) begin
            w_word[l*LANE_WIDTH +: LANE_WIDTH] = data_in[l*LANE_WIDTH +: LANE_WIDTH];
          end
        end
      end
      if (w_addr == '0) begin
        w_word = '0;
      end
    end

    // Output register: data holds when no read is accepted, valid pulses per read.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_data  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_valid <= w_fire;
        if (w_fire) begin
          r_data <= w_word;
        end
      end
    end

    assign rd_data[gi*WORD_W +: WORD_W] = r_data;
    assign rd_valid[gi]                 = r_valid;

`ifdef REG_BANK_PARITY_EN
    logic [LANES-1:0] w_par;
    logic [LANES-1:0] w_perr;
    logic [LANES-1:0] r_perr;

    // Recompute parity of the returned lanes and compare with the stored bits.
    always_comb begin
      w_par = r_par[w_addr];
      if (w_hit) begin
        for (int l = 0; l < LANES; l++) begin
          if (write_mask[l]) begin
            w_par[l] = w_wr_par[l];
          end
        end
      end
      w_perr = '0;
      for (int l = 0; l < LANES; l++) begin
        w_perr[l] = even_parity(MAX_LANE_WIDTH'(w_word[l*LANE_WIDTH +: LANE_WIDTH])) ^ w_par[l];
      end
      if (w_addr == '0) begin
        w_perr = '0;
      end
    end

    // Parity flags are only meaningful alongside a valid read.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_perr <= '0;
      end else if (w_fire) begin
        r_perr <= w_perr;
      end else begin
        r_perr <= '0;
      end
    end

    assign parity_err[gi*LANES +: LANES] = r_perr;
`endif
  end

endmodule

// File: tb/tb_register_bank_gpu_vec.sv
// Scoreboard bench for register_bank_gpu_vec (default geometry 32 x 4 x 32, 2 ports).
// Optional build macro: REG_BANK_PARITY_EN (adds parity flag checks).
module tb_register_bank_gpu_vec;
  import reg_bank_gpu_pkg::*;

  localparam int AW = 5;
  localparam int WW = 128;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             write_en;
  logic [AW-1:0]    write_addr;
  logic [3:0]       write_mask;
  logic [WW-1:0]    data_in;
  logic [1:0]       rd_en;
  logic [2*AW-1:0]  rd_addr;
  logic [2*WW-1:0]  rd_data;
  logic [1:0]       rd_valid;
  logic             clear_req;
  logic             clear_busy;
`ifdef REG_BANK_PARITY_EN
  logic [7:0]       parity_err;
`endif

  register_bank_gpu_vec dut (
    .clk        (clk),
    .reset      (reset),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_mask (write_mask),
    .data_in    (data_in),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
`ifdef REG_BANK_PARITY_EN
    .parity_err (parity_err),
`endif
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .clear_req  (clear_req),
    .clear_busy (clear_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    lane_vec_t  data;
    logic [3:0] perr;
    int         cyc;
  } exp_t;

  exp_t      q0[$];
  exp_t      q1[$];
  lane_vec_t last0 = '0;
  lane_vec_t last1 = '0;
  int        n_cmp = 0;
  int        n_bad = 0;
  int        cyc = 0;

  always @(posedge clk) cyc++;

  localparam lane_vec_t D_FULL  = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;
  localparam lane_vec_t D_ONES  = 128'h11111111_11111111_11111111_11111111;
  localparam lane_vec_t D_MERGE = 128'hDDDD0003_11111111_BBBB0001_11111111;
  localparam lane_vec_t D_R9    = 128'h99990004_99990003_99990002_99990001;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor side: pop an expectation whenever a port presents valid data.
  task automatic mon_port(input int p);
    exp_t       e;
    logic       v;
    lane_vec_t  act;
    int         qs;
    v   = rd_valid[p];
    act = rd_data[p*WW +: WW];
    qs  = (p == 0) ? q0.size() : q1.size();
    if (v) begin
      if (qs == 0) begin
        chk($sformatf("unexpected_valid_p%0d", p), 128'(v), 128'(0));
      end else begin
        e = (p == 0) ? q0.pop_front() : q1.pop_front();
        $display("rd p%0d cyc=%0d data=%h", p, cyc, act);
        chk($sformatf("rd_data_p%0d", p), act, e.data);
        chk($sformatf("rd_latency_p%0d", p), 128'(cyc), 128'(e.cyc));
`ifdef REG_BANK_PARITY_EN
        chk($sformatf("parity_err_p%0d", p), 128'(parity_err[p*4 +: 4]), 128'(e.perr));
`endif
        if (p == 0) last0 = e.data; else last1 = e.data;
      end
    end else begin
      if (qs != 0) begin
        e = (p == 0) ? q0[0] : q1[0];
        if (e.cyc <= cyc) begin
          chk($sformatf("missing_valid_p%0d", p), 128'(v), 128'(1));
          if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
      end
      chk($sformatf("rd_hold_p%0d", p), act, (p == 0) ? last0 : last1);
`ifdef REG_BANK_PARITY_EN
      chk($sformatf("parity_idle_p%0d", p), 128'(parity_err[p*4 +: 4]), 128'(0));
`endif
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      last0 = '0;
      last1 = '0;
    end else begin
      mon_port(0);
      mon_port(1);
    end
  end

  // Stimulus side.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    write_en  = 1'b0;
    write_mask = 4'b0000;
    rd_en     = 2'b00;
    clear_req = 1'b0;
  endtask

  task automatic issue_read(input int p, input int addr, input lane_vec_t d, input logic [3:0] pe);
    exp_t e;
    rd_en[p] = 1'b1;
    rd_addr[p*AW +: AW] = AW'(addr);
    e.data = d;
    e.perr = pe;
    e.cyc  = cyc + 1;
    if (p == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic issue_write(input int addr, input logic [3:0] m, input lane_vec_t d);
    write_en   = 1'b1;
    write_addr = AW'(addr);
    write_mask = m;
    data_in    = d;
    $display("wr r%0d mask=%b data=%h", addr, m, d);
  endtask

  // Count consecutive busy cycles, bounded; returns in the drive phase.
  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (clear_busy) n++;
      else break;
    end
    idle_inputs();
    step();
  endtask

  initial begin
    int n;
    idle_inputs();
    write_addr = '0;
    data_in    = '0;
    rd_addr    = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd_valid", 128'(rd_valid), 128'(0));
    chk("reset_rd_data", rd_data[127:0] | rd_data[255:128], 128'(0));
    chk("reset_clear_busy", 128'(clear_busy), 128'(1));
    reset = 1'b1;
    count_busy(n);
    $display("clear after reset busy=%0d", n);
    chk("busy_after_reset", 128'(n), 128'(31));
    chk("idle_not_busy", 128'(clear_busy), 128'(0));

    // Every register reads zero after the clear
    for (int i = 1; i < 32; i++) begin
      issue_read(i % 2, i, '0, 4'b0000);
      step();
      rd_en = 2'b00;
    end

    // Full write then read
    issue_write(5, 4'b1111, D_FULL);
    step();
    idle_inputs();
    issue_read(0, 5, D_FULL, 4'b0000);
    step();
    idle_inputs();

    // Masked write with same-cycle read: bypass merges lanes
    issue_write(5, 4'b0101, D_ONES);
    issue_read(1, 5, D_MERGE, 4'b0000);
    step();
    idle_inputs();
    issue_read(0, 5, D_MERGE, 4'b0000);
    step();
    idle_inputs();

    // Zero mask is a no-op, even when bypassing
    issue_write(5, 4'b0000, '0);
    issue_read(0, 5, D_MERGE, 4'b0000);
    step();
    idle_inputs();

    // Both ports on the same address
    issue_read(0, 5, D_MERGE, 4'b0000);
    issue_read(1, 5, D_MERGE, 4'b0000);
    step();
    idle_inputs();

    // Register 0 ignores writes and reads zero on both ports
    issue_write(0, 4'b1111, {4{32'hFFFFFFFF}});
    issue_read(1, 0, '0, 4'b0000);
    step();
    idle_inputs();
    issue_read(0, 0, '0, 4'b0000);
    issue_read(1, 0, '0, 4'b0000);
    step();
    idle_inputs();
    @(negedge clk);
    chk("r0_both_valid", 128'(rd_valid), 128'(2'b11));
    step();
    repeat (2) step();

    // Clear request; write and reads during busy are dropped
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    issue_write(7, 4'b1111, 128'h5);
    rd_en = 2'b11;
    rd_addr = {AW'(7), AW'(5)};
    count_busy(n);
    $display("clear on request busy=%0d", n);
    chk("busy_after_req", 128'(n), 128'(31));
    issue_read(0, 7, '0, 4'b0000);
    issue_read(1, 5, '0, 4'b0000);
    step();
    idle_inputs();

    // Reset in the middle of a clear
    issue_write(9, 4'b1111, D_R9);
    step();
    idle_inputs();
    issue_read(1, 9, D_R9, 4'b0000);
    step();
    idle_inputs();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (9) step();
    reset = 1'b0;
    #1;
    chk("midclear_rd_valid", 128'(rd_valid), 128'(0));
    chk("midclear_rd_data", rd_data[255:128], 128'(0));
    chk("midclear_busy", 128'(clear_busy), 128'(1));
    step();
    reset = 1'b1;
    count_busy(n);
    $display("clear after mid-clear reset busy=%0d", n);
    chk("busy_after_midreset", 128'(n), 128'(31));
    issue_read(0, 9, '0, 4'b0000);
    step();
    idle_inputs();

`ifdef REG_BANK_PARITY_EN
    // Stored bit flip in r3 lane 2 shows up as a parity flag on that lane
    issue_write(3, 4'b1111, D_FULL);
    step();
    idle_inputs();
    dut.r_mem[3][64] = ~dut.r_mem[3][64];
    issue_read(0, 3, D_FULL ^ (128'(1) << 64), 4'b0100);
    step();
    idle_inputs();
`endif

    repeat (3) step();
    chk("q0_drained", 128'(q0.size()), 128'(0));
    chk("q1_drained", 128'(q1.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
